// File: rtl/e1_tx_bdq_pkg.sv
// Shared E1 transmit constants and helpers for the buffer-descriptor queue.
// The optional underrun counter is enabled by E1_TX_BDQ_MISS_CNT_EN.
package e1_tx_bdq_pkg;

  localparam int E1_MFW     = 7;
  localparam int CRC_E_W    = 2;
  localparam int MISS_CNT_W = 16;

  function automatic logic [MISS_CNT_W-1:0] sat_inc(input logic [MISS_CNT_W-1:0] v);
    return (&v) ? v : v + MISS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/e1_tx_bdq_fifo.sv
// Synchronous FIFO with extra-bit pointers; a simultaneous pop frees a slot
// for a push when full, and flush empties it by snapping read to write.
module e1_tx_bdq_fifo #(
  parameter int W   = 8,
  parameter int LOG = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << LOG;

  logic [W-1:0] mem [DEPTH];
  logic [LOG:0] wptr, rptr;
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = ((wptr ^ rptr) == {1'b1, {LOG{1'b0}}});
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr[LOG-1:0]];

  // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      rptr <= wptr;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[LOG-1:0]] <= wdata;
  end

endmodule

// File: rtl/e1_tx_bdq.sv
// E1 TX buffer-descriptor queue: submit FIFO, head presentation, done FIFO, status.
// Define E1_TX_BDQ_MISS_CNT_EN to build the saturating underrun counter.
module e1_tx_bdq
  import e1_tx_bdq_pkg::*;
#(
  parameter int MFW  = E1_MFW,
  parameter int QLOG = 2,
  parameter int DLOG = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MFW-1:0]        sub_mf,
  input  logic [CRC_E_W-1:0]    sub_crc_e,
  input  logic                  sub_valid,
  output logic                  sub_ready,
  output logic [MFW-1:0]        bd_mf,
  output logic [CRC_E_W-1:0]    bd_crc_e,
  output logic                  bd_valid,
  input  logic                  bd_done,
  input  logic                  bd_miss,
  output logic [MFW-1:0]        done_mf,
  output logic                  done_valid,
  input  logic                  done_ready,
  input  logic                  ctrl_flush,
  output logic                  stat_ovf,
  output logic                  stat_miss,
  output logic [MISS_CNT_W-1:0] stat_miss_cnt,
  input  logic                  stat_clr
);

  logic sub_full, sub_empty, done_full, done_empty;
  logic sub_push, retire, done_push, done_pop, ovf_evt;

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    sub_push  = 1'b0;
    retire    = 1'b0;
    done_push = 1'b0;
    done_pop  = 1'b0;
    ovf_evt   = 1'b0;
    sub_push  = sub_valid & ~sub_full;
    retire    = bd_done & ~sub_empty;
    done_pop  = done_ready & ~done_empty;
    done_push = retire & ~ctrl_flush;
    // The pop frees the slot first, so only a push into a still-full FIFO is lost.
    ovf_evt   = done_push & done_full & ~done_pop;
  end

  assign sub_ready  = ~sub_full;
  assign bd_valid   = ~sub_empty;
  assign done_valid = ~done_empty;

  e1_tx_bdq_fifo #(.W(MFW + CRC_E_W), .LOG(QLOG)) u_sub_q (
    .clk   (clk),
    .rst   (rst),
    .flush (ctrl_flush),
    .push  (sub_push),
    .pop   (retire),
    .wdata ({sub_mf, sub_crc_e}),
    .rdata ({bd_mf, bd_crc_e}),
    .full  (sub_full),
    .empty (sub_empty)
  );

  e1_tx_bdq_fifo #(.W(MFW), .LOG(DLOG)) u_done_q (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (done_push),
    .pop   (done_pop),
    .wdata (bd_mf),
    .rdata (done_mf),
    .full  (done_full),
    .empty (done_empty)
  );

  // A clear in the same cycle as an event leaves the event's effect standing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ovf  <= 1'b0;
      stat_miss <= 1'b0;
    end else if (stat_clr) begin
      stat_ovf  <= ovf_evt;
      stat_miss <= bd_miss;
    end else begin
      stat_ovf  <= stat_ovf | ovf_evt;
      stat_miss <= stat_miss | bd_miss;
    end
  end

`ifdef E1_TX_BDQ_MISS_CNT_EN
  logic [MISS_CNT_W-1:0] miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           miss_cnt <= '0;
    else if (stat_clr) miss_cnt <= bd_miss ? MISS_CNT_W'(1) : '0;
    else if (bd_miss)  miss_cnt <= sat_inc(miss_cnt);
  end

  assign stat_miss_cnt = miss_cnt;
`else
  assign stat_miss_cnt = '0;
`endif

endmodule

// File: doc/e1_tx_bdq.md
# e1_tx_bdq

Buffer-descriptor queue and scheduler for the E1 transmit path. It accepts multiframe descriptors (buffer multiframe index plus CRC-E bits) from the bus/control logic, presents the head descriptor to the E1 TX core's BD interface, and retires it when the core reports the multiframe done. Completions go to a status FIFO for software. Underruns (multiframe start with no descriptor) are counted.

## Interface
- `MFW`, 7: multiframe index width
- `QLOG`, 2: log2 of submit queue depth (depth 4)
- `DLOG`, 2: log2 of done FIFO depth (depth 4)

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `sub_mf`  in  MFW  multiframe index to queue
- `sub_crc_e`  in  2  CRC-E bits for that multiframe
- `sub_valid`  in  1  submit request
- `sub_ready`  out  1  queue not full
- `bd_mf`  out  MFW  head descriptor index, to TX core
- `bd_crc_e`  out  2  head descriptor CRC-E, to TX core
- `bd_valid`  out  1  queue non-empty
- `bd_done`  in  1  1-cycle pulse from TX core: head multiframe fully sent
- `bd_miss`  in  1  1-cycle pulse from TX core: multiframe started with no descriptor
- `done_mf`  out  MFW  completed multiframe index
- `done_valid`  out  1  done FIFO non-empty
- `done_ready`  in  1  pop done FIFO
- `ctrl_flush`  in  1  1-cycle pulse: empty submit queue
- `stat_ovf`  out  1  sticky: completion dropped (done FIFO full)
- `stat_miss`  out  1  sticky: any bd_miss seen
- `stat_miss_cnt`  out  16  underrun count (macro-dependent)
- `stat_clr`  in  1  clear stickies and counter

## Operation
- Submit queue: FIFO of {mf, crc_e} with `QLOG+1`-bit read/write pointers. The extra bit tells full from empty. A push happens on `sub_valid & sub_ready`.
- Head outputs `bd_mf`/`bd_crc_e` come combinationally from the read-pointer entry. `bd_valid` = not empty.
- Retire: on `bd_done & bd_valid`, pop the head and push `bd_mf` into the done FIFO. A `bd_done` while empty is ignored.
- Done FIFO full at retire: the head is still popped, the completion is discarded, and `stat_ovf` is set.
- Done pop: on `done_valid & done_ready`. Push and pop in the same cycle on a full done FIFO: the pop is taken first, so the push succeeds and `stat_ovf` is not set.
- Submit push with simultaneous retire: both happen, and the count is unchanged. When the queue is full, `sub_ready` is 0 even if a retire happens that cycle; there is no combinational ready path.
- `ctrl_flush`: both submit pointers are set equal (read pointer := write pointer), and any push or retire in the same cycle is discarded. The done FIFO is untouched. Software issues flush only with framing stopped.
- `bd_miss`: sets `stat_miss` and increments the counter, which saturates at 16'hFFFF.
- `stat_clr`: clears `stat_ovf`, `stat_miss` and the counter. If `stat_clr` and a miss occur in the same cycle, the counter becomes 1 and `stat_miss` becomes 1. The same rule applies to `stat_ovf` with an overflow event.
- No FSM beyond the pointer logic. The TX core latches `bd_valid` at multiframe start itself.

## Timing
- Reset values: `sub_ready`=1, `bd_valid`=0, `done_valid`=0, stats=0. `bd_mf`, `bd_crc_e` and `done_mf` are don't-care while their valid is 0.
- Submit-to-`bd_valid` latency: 1 cycle (registered pointer).
- `bd_done`-to-next-head latency: 1 cycle. `bd_done` is already registered by the TX core, so the next head is presented at least 1 cycle before the next multiframe's first request.
- `bd_done`-to-`done_valid`: 1 cycle.
- All status outputs are registered, with 1-cycle latency.

## Configuration
- `E1_TX_BDQ_MISS_CNT_EN` defined: 16-bit saturating counter as above.
- Not defined: no counter flops are built, `stat_miss_cnt` is tied to 0, and `stat_miss` is still implemented.

## Structure
- The shared E1 header holds the default `MFW`, the CRC-E width constant (2) and the counter width (16).
- One sub-module: `e1_tx_bdq_fifo`, a parameterised sync FIFO (width, log depth) with full/empty flags. It is instantiated twice, once for the submit queue and once for the done FIFO.

## Test plan
- Push mf=3, 5, 9 → `bd_valid`=1 with `bd_mf`=3. After `bd_done`, `bd_mf`=5 and `done_mf`=3 with `done_valid`=1.
- Push 4 entries → `sub_ready`=0. A 5th `sub_valid` is ignored. After one `bd_done`, `sub_ready`=1 on the next cycle.
- Hold `done_ready`=0 and retire 5 multiframes → 4 completions are held and `stat_ovf`=1. Popping yields 0..3 in order.
- Pulse `bd_miss` 3 times → `stat_miss`=1 and cnt=3 (cnt=0 if the macro is undefined). `stat_clr` together with `bd_miss` → cnt=1.
- Queue holds 3 entries. `ctrl_flush` in the same cycle as `bd_done` → `bd_valid`=0 and no done entry is pushed.
- Assert `rst` mid-operation with both FIFOs non-empty → all outputs return to their reset values asynchronously. After release, a push of mf=7 works normally.
